// File: rtl/cpu_trace_pkg.sv
// -----------------------------------------------------------------------------
// cpu_trace_pkg
//   Shared definitions for the CPU trace buffer: FSM state encoding, default
//   capacity, the 99-bit trace record layout and the flag bit positions.
// -----------------------------------------------------------------------------
package cpu_trace_pkg;

    // Capture FSM encoding; the raw value is visible on the 'state' port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Default record capacity (must be a power of two).
    localparam int unsigned TRACE_DEPTH_DEF = 16;

    // Record = PC + IR + ALUOut + 3 status flags.
    localparam int unsigned REC_W  = 99;
    localparam int unsigned FLAG_W = 3;

    // Bit positions inside the flag field, so flags read back as {jump,branch,zero}.
    localparam int unsigned FLAG_ZERO   = 0;
    localparam int unsigned FLAG_BRANCH = 1;
    localparam int unsigned FLAG_JUMP   = 2;

    typedef struct packed {
        logic [FLAG_W-1:0] flags;
        logic [31:0]       alu;
        logic [31:0]       ir;
        logic [31:0]       pc;
    } trace_rec_t;

    // True in the states where retiring records are stored.
    function automatic logic is_capture_state(input trace_state_e s);
        return (s == ST_ARMED) || (s == ST_POST);
    endfunction

    // True in the states where the consumer may read records.
    function automatic logic is_read_state(input trace_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage : cpu_trace_pkg

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
//   DEPTH x WIDTH register array holding trace records.
//   One synchronous write port, one asynchronous (combinational) read port.
//
// Ports
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, follows raddr_i combinationally
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 99
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count in the parent, so stale contents are never observed.
    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : trace_ram

// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//   Triggered circular trace buffer for a CPU. An 'arm' pulse clears the
//   buffer and starts a run; retiring records are captured continuously
//   (oldest overwritten when full) until the PC trigger hits, then post_cnt
//   further records are captured and the run stops. Records are drained
//   through a valid/ready read port once the run is done.
//
// Ports
//   clk                        in   system clock, rising edge
//   reset                      in   asynchronous active-low reset
//   arm                        in   pulse: clear buffer, start capture run
//   trig_pc[31:0]              in   trigger PC
//   post_cnt[3:0]              in   records to capture after the trigger
//   cap_valid                  in   CPU record inputs are valid this cycle
//   pc_in/ir_in/alu_in[31:0]   in   CPU PC, IR, ALUOut
//   zero_in/branch_in/jump_in  in   CPU status flags
//   rd_ready                   in   consumer accepts head record
//   rd_valid                   out  head record available
//   rd_pc/rd_ir/rd_alu[31:0]   out  head record fields (zero when invalid)
//   rd_flags[2:0]              out  head record {jump,branch,zero}
//   count                      out  number of stored records
//   state[1:0]                 out  FSM state
//   overflow                   out  sticky: a record was overwritten this run
// -----------------------------------------------------------------------------
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic [31:0]               trig_pc,
    input  logic [3:0]                post_cnt,
    input  logic                      cap_valid,
    input  logic [31:0]               pc_in,
    input  logic [31:0]               ir_in,
    input  logic [31:0]               alu_in,
    input  logic                      zero_in,
    input  logic                      branch_in,
    input  logic                      jump_in,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [31:0]               rd_pc,
    output logic [31:0]               rd_ir,
    output logic [31:0]               rd_alu,
    output logic [2:0]                rd_flags,
    output logic [$clog2(DEPTH):0]    count,
    output logic [1:0]                state,
    output logic                      overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    trace_state_e   state_q;
    logic [3:0]     remaining_q;

    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;

    // -------------------------------------------------------------------------
    // Control strobes
    // -------------------------------------------------------------------------
    logic       wr_en;
    logic       pop;
    logic       full;
    logic       trig_hit;
    trace_rec_t wr_rec;
    trace_rec_t head_rec;
    logic [REC_W-1:0] ram_rdata;

    assign full     = (count_q == CNT_FULL);
    assign trig_hit = (pc_in == trig_pc);

    // arm wins over both capture and pop in the same cycle.
    assign wr_en    = cap_valid && is_capture_state(state_q) && !arm;
    assign rd_valid = is_read_state(state_q) && (count_q != '0);
    assign pop      = rd_valid && rd_ready && !arm;

    // -------------------------------------------------------------------------
    // Record assembly
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch
        // is inferred on paths that do not assign it.
        wr_rec                    = '0;
        wr_rec.pc                 = pc_in;
        wr_rec.ir                 = ir_in;
        wr_rec.alu                = alu_in;
        wr_rec.flags[FLAG_ZERO]   = zero_in;
        wr_rec.flags[FLAG_BRANCH] = branch_in;
        wr_rec.flags[FLAG_JUMP]   = jump_in;
    end

    // -------------------------------------------------------------------------
    // Pointer / count / overflow next state
    // -------------------------------------------------------------------------
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (arm) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (wr_en) begin
            tail_d = tail_q + PTR_ONE;
            if (full) begin
                // Oldest record is overwritten: head follows tail, count holds.
                head_d     = head_q + PTR_ONE;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (pop) begin
            // Writes and pops are never concurrent: they live in disjoint states.
            head_d  = head_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Capture FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else if (arm) begin
            state_q     <= ST_ARMED;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_ARMED: begin
                    if (cap_valid && trig_hit) begin
                        if (post_cnt == 4'd0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q     <= ST_POST;
                            remaining_q <= post_cnt;
                        end
                    end
                end
                ST_POST: begin
                    // A PC match here is an ordinary record; only the count matters.
                    if (cap_valid) begin
                        remaining_q <= remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (pop && (count_q == CNT_ONE)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Record storage
    // -------------------------------------------------------------------------
    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_trace_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (tail_q),
        .wdata_i (wr_rec),
        .raddr_i (head_q),
        .rdata_o (ram_rdata)
    );

    assign head_rec = ram_rdata;

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Unwritten storage may hold X; masking with rd_valid keeps the port clean.
    assign rd_pc    = rd_valid ? head_rec.pc    : 32'd0;
    assign rd_ir    = rd_valid ? head_rec.ir    : 32'd0;
    assign rd_alu   = rd_valid ? head_rec.alu   : 32'd0;
    assign rd_flags = rd_valid ? head_rec.flags : 3'd0;

    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule : cpu_trace_buffer

// File: tb/tb_cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_buffer
//   Self-checking bench for cpu_trace_buffer. Captured records are pushed to
//   a scoreboard queue and compared against the read port as they drain.
// -----------------------------------------------------------------------------
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [31:0] trig_pc;
    logic [3:0]  post_cnt;
    logic        cap_valid;
    logic [31:0] pc_in, ir_in, alu_in;
    logic        zero_in, branch_in, jump_in;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_ir, rd_alu;
    logic [2:0]  rd_flags;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        overflow;

    cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .cap_valid (cap_valid),
        .pc_in     (pc_in),
        .ir_in     (ir_in),
        .alu_in    (alu_in),
        .zero_in   (zero_in),
        .branch_in (branch_in),
        .jump_in   (jump_in),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_pc     (rd_pc),
        .rd_ir     (rd_ir),
        .rd_alu    (rd_alu),
        .rd_flags  (rd_flags),
        .count     (count),
        .state     (state),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard and reference model
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [2:0]  flags;
    } rec_t;

    rec_t         sb[$];
    trace_state_e m_state;
    logic [3:0]   m_rem;
    logic         m_ovf;
    logic [31:0]  last_pc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input trace_state_e s);
        sb.delete();
        m_state = s;
        m_rem   = 4'd0;
        m_ovf   = 1'b0;
    endtask

    task automatic capture(input logic [31:0] pc, input logic [2:0] fl);
        rec_t r;
        r.pc    = pc;
        r.ir    = pc ^ 32'hA5A5_5A5A;
        r.alu   = pc + 32'h1000_0000;
        r.flags = fl;
        cap_valid = 1'b1;
        pc_in     = r.pc;
        ir_in     = r.ir;
        alu_in    = r.alu;
        {jump_in, branch_in, zero_in} = fl;
        step();
        cap_valid = 1'b0;
        if (m_state == ST_ARMED || m_state == ST_POST) begin
            sb.push_back(r);
            if (sb.size() > DEPTH) begin
                sb.delete(0);
                m_ovf = 1'b1;
            end
            if (m_state == ST_ARMED) begin
                if (pc == trig_pc) begin
                    if (post_cnt == 4'd0) begin
                        m_state = ST_DONE;
                    end else begin
                        m_state = ST_POST;
                        m_rem   = post_cnt;
                    end
                end
            end else begin
                m_rem = m_rem - 4'd1;
                if (m_rem == 4'd0) m_state = ST_DONE;
            end
        end
    endtask

    task automatic do_arm(input logic with_ready);
        arm      = 1'b1;
        rd_ready = with_ready;
        step();
        arm      = 1'b0;
        rd_ready = 1'b0;
        model_clear(ST_ARMED);
    endtask

    task automatic check_status(input string tag);
        logic exp_valid;
        exp_valid = (m_state == ST_IDLE || m_state == ST_DONE) && (sb.size() != 0);
        check({tag, ".state"},    64'(state),    64'(m_state));
        check({tag, ".count"},    64'(count),    64'(sb.size()));
        check({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(exp_valid));
    endtask

    // One read-port cycle: compare head against scoreboard, optionally pop.
    task automatic read_cycle(input string tag, input logic ready);
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check({tag, ".rd_pc"},    64'(rd_pc),    64'(sb[0].pc));
            check({tag, ".rd_ir"},    64'(rd_ir),    64'(sb[0].ir));
            check({tag, ".rd_alu"},   64'(rd_alu),   64'(sb[0].alu));
            check({tag, ".rd_flags"}, 64'(rd_flags), 64'(sb[0].flags));
        end
        rd_ready = ready;
        step();
        rd_ready = 1'b0;
        if (ready && sb.size() != 0) begin
            last_pc = sb[0].pc;
            sb.delete(0);
            if (sb.size() == 0 && m_state == ST_DONE) m_state = ST_IDLE;
        end
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb.size() != 0 && guard < 64) begin
            read_cycle(tag, 1'b1);
            guard++;
        end
        check({tag, ".drain_bound"}, 64'(sb.size()), 64'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [2:0] pattern [4];

        reset = 1'b0; arm = 1'b0; trig_pc = '0; post_cnt = '0;
        cap_valid = 1'b0; pc_in = '0; ir_in = '0; alu_in = '0;
        zero_in = 1'b0; branch_in = 1'b0; jump_in = 1'b0; rd_ready = 1'b0;
        last_pc = '0;
        model_clear(ST_IDLE);

        // Reset state, before any clock edge.
        #2;
        check("reset.state",    64'(state),    64'd0);
        check("reset.count",    64'(count),    64'd0);
        check("reset.rd_valid", 64'(rd_valid), 64'd0);
        check("reset.rd_pc",    64'(rd_pc),    64'd0);
        check("reset.overflow", 64'(overflow), 64'd0);
        step();
        reset = 1'b1;
        step();

        // cap_valid is ignored in IDLE.
        capture(32'h40, 3'b111);
        check_status("idle_ignore");

        // ---- basic ----
        trig_pc = 32'h10; post_cnt = 4'd2;
        do_arm(1'b0);
        check("basic.armed", 64'(state), 64'd1);
        for (int i = 0; i < 7; i++) begin
            capture(32'(i * 4), 3'(i));
            if (i == 3) check_status("basic.pre_trig");
            if (i == 4) check("basic.post", 64'(state), 64'd2);
        end
        check("basic.done",  64'(state), 64'd3);
        check("basic.count", 64'(count), 64'd7);
        check_status("basic.status");
        for (int i = 0; i < 7; i++) begin
            check("basic.order", 64'(rd_pc), 64'(i * 4));
            read_cycle("basic.read", 1'b1);
        end
        check("basic.idle",  64'(state),    64'd0);
        check("basic.empty", 64'(rd_valid), 64'd0);

        // ---- overflow ----
        trig_pc = 32'h50; post_cnt = 4'd0;
        do_arm(1'b0);
        for (int i = 0; i < 20; i++) capture(32'(i * 4), 3'b010);
        capture(32'h50, 3'b100);
        check("ovf.count",    64'(count),    64'd16);
        check("ovf.flag",     64'(overflow), 64'd1);
        check("ovf.state",    64'(state),    64'd3);
        check("ovf.first_pc", 64'(rd_pc),    64'h14);
        check_status("ovf.status");
        drain("ovf.read");
        check("ovf.last_pc", 64'(last_pc), 64'h50);
        check("ovf.idle",    64'(state),   64'd0);

        // ---- re-arm ----
        trig_pc = 32'h8; post_cnt = 4'd2;
        do_arm(1'b0);
        check("rearm.ovf_clear", 64'(overflow), 64'd0);
        capture(32'h0, 3'b000);
        capture(32'h8, 3'b001);
        check("rearm.in_post", 64'(state), 64'd2);
        do_arm(1'b0);
        check_status("rearm.from_post");
        capture(32'h8, 3'b001);
        capture(32'h8, 3'b010);
        check("rearm.no_retrig", 64'(state), 64'd2);
        capture(32'hC, 3'b100);
        check("rearm.done",  64'(state), 64'd3);
        check("rearm.count", 64'(count), 64'd3);
        do_arm(1'b1);
        check("rearm.state_armed", 64'(state),    64'd1);
        check("rearm.count_zero",  64'(count),    64'd0);
        check("rearm.ovf_zero",    64'(overflow), 64'd0);
        check("rearm.no_valid",    64'(rd_valid), 64'd0);

        // ---- backpressure ----
        trig_pc = 32'h100; post_cnt = 4'd2;
        capture(32'h100, 3'b011);
        capture(32'h104, 3'b101);
        capture(32'h108, 3'b110);
        check("bp.count", 64'(count), 64'd3);
        check_status("bp.status");
        pattern[0] = 3'd1; pattern[1] = 3'd0; pattern[2] = 3'd1; pattern[3] = 3'd1;
        for (int k = 0; k < 4; k++) read_cycle("bp.read", pattern[k][0]);
        check("bp.valid_low", 64'(rd_valid), 64'd0);
        check("bp.idle",      64'(state),    64'd0);
        check("bp.rd_zero",   64'(rd_pc),    64'd0);

        // ---- reset mid-run ----
        trig_pc = 32'h200; post_cnt = 4'd5;
        do_arm(1'b0);
        for (int i = 0; i < 5; i++) capture(32'h1F0 + 32'(i * 4), 3'b001);
        check("rst.post",  64'(state), 64'd2);
        check("rst.count", 64'(count), 64'd5);
        #3;
        reset = 1'b0;
        #1;
        check("rst.state_now", 64'(state),    64'd0);
        check("rst.count_now", 64'(count),    64'd0);
        check("rst.valid_now", 64'(rd_valid), 64'd0);
        check("rst.ovf_now",   64'(overflow), 64'd0);
        model_clear(ST_IDLE);
        step();
        reset = 1'b1;
        step();
        capture(32'h204, 3'b111);
        capture(32'h200, 3'b111);
        check_status("rst.ignore");

        // ---- flags and gaps ----
        trig_pc = 32'h300; post_cnt = 4'd1;
        do_arm(1'b0);
        capture(32'h2F0, 3'b001);
        pc_in = 32'h300; cap_valid = 1'b0;
        step();
        check("gap.count", 64'(count), 64'd1);
        check("gap.state", 64'(state), 64'd1);
        capture(32'h300, 3'b110);
        pc_in = 32'h999; cap_valid = 1'b0;
        step();
        capture(32'h304, 3'b001);
        check("gap.done",   64'(state),    64'd3);
        check("gap.count3", 64'(count),    64'd3);
        check("gap.flag0",  64'(rd_flags), 64'h1);
        drain("gap.read");
        check_status("gap.final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_trace_buffer

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace record capacity; must be a power of two.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port arm  input  1  one-cycle pulse that clears the buffer and starts a capture run.
REQ-005 SHALL have port trig_pc  input  32  PC value that triggers the run.
REQ-006 SHALL have port post_cnt  input  4  records captured after the trigger record; sampled when the trigger hits.
REQ-007 SHALL have port cap_valid  input  1  the CPU's pc_in/ir_in/alu_in/flags are a retiring record this cycle.
REQ-008 SHALL have ports pc_in, ir_in, alu_in  input  32 each  CPU PC, IR and ALUOut values.
REQ-009 SHALL have ports zero_in, branch_in, jump_in  input  1 each  CPU status flags.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts the head record.
REQ-011 SHALL have port rd_valid  output  1  head record available.
REQ-012 SHALL have ports rd_pc, rd_ir, rd_alu  output  32 each, and rd_flags  output  3 {jump,branch,zero}, carrying the head record.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  number of stored records.
REQ-014 SHALL have port state  output  2  FSM state encoding.
REQ-015 SHALL have port overflow  output  1  sticky flag: at least one record was overwritten this run.

Function
REQ-016 SHALL implement the FSM states IDLE=0, ARMED=1, POST=2 and DONE=3.
REQ-017 SHALL transition from any state to ARMED on arm, clearing the pointers, count and overflow on the same edge; arm takes priority over cap_valid and pop in that cycle.
REQ-018 In IDLE and DONE, SHALL ignore cap_valid.
REQ-019 In ARMED or POST with cap_valid=1, SHALL write the record at the tail pointer on that edge.
REQ-020 When a write occurs with count=DEPTH, SHALL overwrite the oldest record: head advances, count stays DEPTH, and overflow is set.
REQ-021 In ARMED, on cap_valid with pc_in==trig_pc, SHALL write that record and go to DONE if post_cnt=0, otherwise go to POST with remaining=post_cnt.
REQ-022 In POST, each cap_valid SHALL write and decrement remaining; the write that brings remaining to 0 SHALL move the FSM to DONE.
REQ-023 In POST, a pc_in==trig_pc match SHALL NOT retrigger.
REQ-024 SHALL drive rd_valid = (state is IDLE or DONE) and count!=0; reads are blocked in ARMED and POST.
REQ-025 SHALL drive rd_* combinationally from the head entry while rd_valid=1, and as all zeros while rd_valid=0.
REQ-026 SHALL pop on rd_valid && rd_ready: head advances and count decrements on that edge.
REQ-027 A pop in DONE that empties the buffer SHALL move the FSM to IDLE.
REQ-028 SHALL wrap both pointers modulo DEPTH with no bubble.
REQ-029 SHALL make a captured record readable no earlier than the cycle after the DONE transition.

Reset
REQ-030 While reset=0, SHALL force state=IDLE, head=tail=0, count=0, remaining=0, overflow=0, and therefore rd_valid=0 and rd_*=0, regardless of clk.
REQ-031 SHALL NOT reset record storage contents.
REQ-032 Reset asserted mid-run or mid-drain SHALL discard the run entirely; no partial state survives.

Structure
REQ-033 SHALL place the following in shared package cpu_trace_pkg: the state encoding, DEPTH default, record width 99, and flag bit indices (zero=0, branch=1, jump=2).
REQ-034 SHALL instantiate one sub-module, trace_ram: a DEPTH x 99 register array with one synchronous write port, one asynchronous read port, and no reset.
REQ-035 SHALL keep the FSM, pointers, counters and flags in cpu_trace_buffer.

Verification
REQ-036 Scenario basic: arm; trig_pc=0x0000_0010, post_cnt=2; cap_valid with PCs 0x0,0x4,...,0x18 -> DONE after PC 0x18; count=7; reads return 0x0..0x18 in order; IDLE after last pop.
REQ-037 Scenario overflow: DEPTH=16, 20 captures in ARMED before the trigger (PCs 0x0..0x4C), trigger at 0x50 with post_cnt=0 -> count=16, overflow=1, first read PC=0x14, last read PC=0x50.
REQ-038 Scenario re-arm: arm pulses in POST, and again in DONE with rd_ready=1 in the same cycle -> state=ARMED, count=0, overflow=0, no pop observed.
REQ-039 Scenario backpressure: in DONE with count=3, toggle rd_ready 1,0,1,1 -> rd_* holds while ready=0; 3 pops; rd_valid=0 and state=IDLE afterwards.
REQ-040 Scenario reset mid-run: reset low asynchronously (between clk edges) in POST with count=5 -> state=IDLE, count=0 and rd_valid=0 immediately; after release, cap_valid is ignored until arm.
REQ-041 Scenario flags and gaps: captures with cap_valid gaps and flag patterns 3'b001, 3'b110 -> rd_flags matches per record; no records are written for cycles with cap_valid=0.
